mem_wb_stage: RTL

Consumer end of the EX/MEM pipeline register. Takes the registered EX/MEM fields and resolves branches. Runs load/store accesses against a data memory over a req/ack handshake with variable latency, stalling the upstream pipeline while an access is outstanding. Drives the MEM/WB register that feeds writeback.

---
 rtl/mem_wb_stage.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/mem_wb_stage.sv
// MEM stage: resolves branches, runs load/store accesses over a req/ack data-memory
// handshake (stalling upstream while outstanding) and drives the MEM/WB register.
module mem_wb_stage #(
    parameter int TIMEOUT = 16,
    parameter int AW      = 64
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [63:0]   PCSum2,
    input  logic [63:0]   ALUResult2,
    input  logic [63:0]   ReadData2out,
    input  logic          Branch2,
    input  logic          MemRead2,
    input  logic          MemtoReg2,
    input  logic          MemWrite2,
    input  logic          RegWrite2,
    input  logic          Zero2,
    input  logic [4:0]    Rd2,
    output logic          dmem_req,
    output logic          dmem_we,
    output logic [AW-1:0] dmem_addr,
    output logic [63:0]   dmem_wdata,
    input  logic          dmem_ack,
    input  logic [63:0]   dmem_rdata,
    output logic          stall_mem,
    output logic          pc_src,
    output logic [63:0]   branch_target,
    output logic          flush_EXMEM,
    output logic          RegWrite_wb,
    output logic          MemtoReg_wb,
    output logic [63:0]   ALUResult_wb,
    output logic [63:0]   ReadData_wb,
    output logic [4:0]    Rd_wb,
    output logic          mem_fault
);
    localparam int CW = $clog2(TIMEOUT) + 1;
    // Timeout fires in the wait cycle whose increment would bring the counter to TIMEOUT-1.
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 2);

    typedef enum logic {S_IDLE = 1'b0, S_WAIT = 1'b1} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          fault_q, fault_d;

    logic          mem_op, misaligned, req, timeout_hit, misalign_hit, bubble, load_ack;

    logic          rw_q, rw_d, m2r_q, m2r_d;
    logic [63:0]   alu_q, alu_d, rdata_q, rdata_d;
    logic [4:0]    rd_q, rd_d;

    assign mem_op     = MemRead2 | MemWrite2;
    assign misaligned = mem_op & (ALUResult2[2:0] != 3'b000);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            fault_q <= fault_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (mem_op && !misaligned && !dmem_ack) begin
                    state_d = S_WAIT;
                    cnt_d   = '0;
                end
            end
            S_WAIT: begin
                if (dmem_ack || timeout_hit) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        req         = 1'b0;
        timeout_hit = 1'b0;
        case (state_q)
            S_IDLE:  req = mem_op & ~misaligned;
            S_WAIT: begin
                req         = 1'b1;
                timeout_hit = ~dmem_ack & (cnt_q == CNT_LAST);
            end
            default: req = 1'b0;
        endcase
        req = req & ~reset;
    end

    assign misalign_hit = (state_q == S_IDLE) & misaligned & ~reset;
    assign stall_mem    = req & ~dmem_ack & ~timeout_hit;
    assign bubble       = stall_mem | timeout_hit | misalign_hit;
    assign load_ack     = req & dmem_ack & MemRead2 & ~MemWrite2;
    assign fault_d      = fault_q | timeout_hit | misalign_hit;

    assign dmem_req      = req;
    assign dmem_we       = req & MemWrite2;
    assign dmem_addr     = ALUResult2[AW-1:0];
    assign dmem_wdata    = ReadData2out;
    assign pc_src        = Branch2 & Zero2 & ~stall_mem;
    assign flush_EXMEM   = pc_src;
    assign branch_target = PCSum2;
    assign mem_fault     = fault_q;

    always_comb begin
        rw_d    = 1'b0;
        m2r_d   = 1'b0;
        alu_d   = '0;
        rd_d    = '0;
        rdata_d = '0;
        if (!bubble) begin
            rw_d    = RegWrite2 & (Rd2 != 5'd0);
            m2r_d   = MemtoReg2;
            alu_d   = ALUResult2;
            rd_d    = Rd2;
            rdata_d = load_ack ? dmem_rdata : 64'd0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rw_q    <= 1'b0;
            m2r_q   <= 1'b0;
            alu_q   <= '0;
            rd_q    <= '0;
            rdata_q <= '0;
        end else begin
            rw_q    <= rw_d;
            m2r_q   <= m2r_d;
            alu_q   <= alu_d;
            rd_q    <= rd_d;
            rdata_q <= rdata_d;
        end
    end

    assign RegWrite_wb  = rw_q;
    assign MemtoReg_wb  = m2r_q;
    assign ALUResult_wb = alu_q;
    assign ReadData_wb  = rdata_q;
    assign Rd_wb        = rd_q;
endmodule
